// File: rtl/counter_pkg.sv
// counter_pkg: shared mode constants and load clamping for counter_updown_mod.
package counter_pkg;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;
   function automatic int clamp_load(input int val, input int mod);
      return (val >= mod) ? mod - 1 : val;
   endfunction
endpackage

// File: rtl/counter_updown_mod_edge_trig.sv
// edge_trig: one-cycle trigger on each rising edge of x; an optional debouncer
// sits in front of the edge detector when COUNTER_DEBOUNCE_EN is defined.
module edge_trig #(
   parameter int DEB_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic trig
);
   logic x_in, x_q, trig_q;
`ifdef COUNTER_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYC + 1);
   logic [CW-1:0] cnt_q;
   logic deb_q;
   // deb_q follows x only after DEB_CYC consecutive samples disagree with it
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else if (x == deb_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEB_CYC - 1)) begin
         cnt_q <= '0;
         deb_q <= x;
      end else cnt_q <= cnt_q + 1'b1;
   assign x_in = deb_q;
`else
   assign x_in = x;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         x_q    <= 1'b0;
         trig_q <= 1'b0;
      end else begin
         x_q    <= x_in;
         trig_q <= x_in & ~x_q;
      end
   assign trig = trig_q;
   if (DEB_CYC < 1) begin : g_bad_deb
      $error("edge_trig: DEB_CYC must be >= 1");
   end
endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: edge-triggered up/down modulo counter with load, wrap/saturate and tc pulse.
// Define COUNTER_DEBOUNCE_EN to debounce x_up/x_dn before edge detection.
module counter_updown_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MOD      = 10,
   parameter int SAT_MODE = MODE_WRAP,
   parameter int DEB_CYC  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_up,
   input  logic             x_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state,
   output logic             tc
);
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
   logic up_trig, dn_trig, tc_q, tc_d;
   logic [WIDTH-1:0] state_q, state_d;
   edge_trig #(.DEB_CYC(DEB_CYC)) u_up (.clk(clk), .rst(rst), .x(x_up), .trig(up_trig));
   edge_trig #(.DEB_CYC(DEB_CYC)) u_dn (.clk(clk), .rst(rst), .x(x_dn), .trig(dn_trig));
   // load wins and swallows any trigger arriving in the same cycle
   always_comb begin
      state_d = state_q;
      tc_d    = 1'b0;
      if (load) state_d = WIDTH'(clamp_load(int'(load_val), MOD));
      else if (up_trig && !dn_trig) begin
         tc_d    = (state_q == TOP);
         state_d = !tc_d ? state_q + 1'b1 : (SAT_MODE == MODE_WRAP) ? '0 : state_q;
      end else if (dn_trig && !up_trig) begin
         tc_d    = (state_q == '0);
         state_d = !tc_d ? state_q - 1'b1 : (SAT_MODE == MODE_WRAP) ? TOP : state_q;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
      end
   assign state = state_q;
   assign tc    = tc_q;
   if (WIDTH < 2 || WIDTH > 16 || MOD < 2 || MOD > 2**WIDTH ||
       (SAT_MODE != MODE_WRAP && SAT_MODE != MODE_SAT)) begin : g_bad_cfg
      $error("counter_updown_mod: parameter out of range");
   end
endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: scoreboard bench driving a wrap and a saturate counter with shared stimulus.
module tb_counter_updown_mod;
   logic clk = 1'b0, rst = 1'b0, x_up = 1'b0, x_dn = 1'b0, load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] state_w, state_s;
   logic tc_w, tc_s;
   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(4), .MOD(10), .SAT_MODE(0), .DEB_CYC(4)) u_wrap (
      .clk(clk), .rst(rst), .x_up(x_up), .x_dn(x_dn), .load(load),
      .load_val(load_val), .state(state_w), .tc(tc_w));
   counter_updown_mod #(.WIDTH(4), .MOD(10), .SAT_MODE(1), .DEB_CYC(4)) u_sat (
      .clk(clk), .rst(rst), .x_up(x_up), .x_dn(x_dn), .load(load),
      .load_val(load_val), .state(state_s), .tc(tc_s));

   typedef struct {int sw; bit tw; int ss; bit ts;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int m_w, m_s;
   bit prev_up, prev_dn, pend_up, pend_dn;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && q.size() > 0) begin
         e = q.pop_front();
         chk("state_wrap", int'(state_w), e.sw);
         chk("tc_wrap", int'(tc_w), int'(e.tw));
         chk("state_sat", int'(state_s), e.ss);
         chk("tc_sat", int'(tc_s), int'(e.ts));
      end
   end

   task automatic model_reset();
      m_w = 0; m_s = 0;
      prev_up = 0; prev_dn = 0; pend_up = 0; pend_dn = 0;
   endtask

   // A press first seen at one edge moves the count at the following edge.
   task automatic cycle(input bit up, input bit dn, input bit ld, input int lv);
      exp_t e;
      x_up = up; x_dn = dn; load = ld; load_val = 4'(lv);
      @(posedge clk);
      e.tw = 0; e.ts = 0;
      if (ld) begin
         m_w = (lv >= 10) ? 9 : lv;
         m_s = m_w;
      end else if (pend_up && !pend_dn) begin
         e.tw = (m_w == 9); m_w = (m_w + 1) % 10;
         e.ts = (m_s == 9); if (m_s < 9) m_s++;
      end else if (pend_dn && !pend_up) begin
         e.tw = (m_w == 0); m_w = (m_w + 9) % 10;
         e.ts = (m_s == 0); if (m_s > 0) m_s--;
      end
      pend_up = up && !prev_up; prev_up = up;
      pend_dn = dn && !prev_dn; prev_dn = dn;
      e.sw = m_w; e.ss = m_s;
      q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      bit ld;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", int'(state_w), 0);
      chk("reset_tc", int'(tc_w), 0);
      chk("reset_state_sat", int'(state_s), 0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 0, 0, 0);
         cycle(0, 0, 0, 0);
      end
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0); cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 5); cycle(1, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 3); cycle(1, 0, 0, 0); cycle(1, 0, 1, 12);
      cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 7); cycle(0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_state", int'(state_w), 0);
      chk("async_rst_tc", int'(tc_w), 0);
      chk("async_rst_state_sat", int'(state_s), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 400; i++) begin
         ld = ($urandom_range(0, 9) == 0);
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ld, int'($urandom_range(0, 15)));
      end
      cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
